// File: rtl/rr_dispatch_1to4.sv
// rr_dispatch_1to4: round-robin 1-to-4 dispatcher with a one-entry holding
// register per lane. Optional macro RR_DISPATCH_SKIP_BUSY_EN switches the
// target choice from strict rotation to "first free lane from ptr".

// One lane: holding register with valid bit; a load in the same cycle as a
// drain keeps the lane valid with the new word.
module rr_dispatch_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rdy,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             free
);
    // free also when draining this cycle, so refill is bubble-free
    assign free = ~vld | rdy;

    // Load wins over drain; data is kept (not cleared) after a drain
    always_ff @(posedge clk) begin
        if (rst) begin
            vld  <= 1'b0;
            data <= '0;
        end else if (wr) begin
            vld  <= 1'b1;
            data <= wdata;
        end else if (rdy) begin
            vld  <= 1'b0;
        end
    end
endmodule

module rr_dispatch_1to4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_valid2,
    output logic             out_valid3,
    input  logic             out_ready0,
    input  logic             out_ready1,
    input  logic             out_ready2,
    input  logic             out_ready3,
    output logic             sel0,
    output logic             sel1,
    output logic             busy
);
    localparam int NUM_LANES = 4;

    logic [1:0]                        ptr;
    logic [1:0]                        target;
    logic                              can_take;
    logic                              accept;
    logic [NUM_LANES-1:0]              lane_rdy;
    logic [NUM_LANES-1:0]              lane_vld;
    logic [NUM_LANES-1:0]              lane_free;
    logic [NUM_LANES-1:0]              lane_wr;
    logic [NUM_LANES-1:0][WIDTH-1:0]   lane_data;

    assign lane_rdy = {out_ready3, out_ready2, out_ready1, out_ready0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        rr_dispatch_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr    (lane_wr[i]),
            .wdata (in_data),
            .rdy   (lane_rdy[i]),
            .vld   (lane_vld[i]),
            .data  (lane_data[i]),
            .free  (lane_free[i])
        );
    end

`ifdef RR_DISPATCH_SKIP_BUSY_EN
    logic [1:0] idx;
    logic       found;

    // First free lane searching ptr, ptr+1, ptr+2, ptr+3; stalled lanes skipped
    always_comb begin
        target = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = ptr + 2'(k);
            if (!found && lane_free[idx]) begin
                target = idx;
                found  = 1'b1;
            end
        end
    end
    assign can_take = found;
`else
    // Strict rotation: only lane ptr may take the word
    assign target   = ptr;
    assign can_take = lane_free[ptr];
`endif

    assign in_ready = can_take & ~rst;
    assign accept   = in_valid & in_ready;
    assign lane_wr  = {NUM_LANES{accept}} & (NUM_LANES'(1) << target);

    // Pointer moves past the lane just written; holds when nothing is accepted
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (accept)
            ptr <= target + 2'd1;
    end

    assign sel0       = ptr[0];
    assign sel1       = ptr[1];
    assign busy       = |lane_vld;
    assign out_data0  = lane_data[0];
    assign out_data1  = lane_data[1];
    assign out_data2  = lane_data[2];
    assign out_data3  = lane_data[3];
    assign out_valid0 = lane_vld[0];
    assign out_valid1 = lane_vld[1];
    assign out_valid2 = lane_vld[2];
    assign out_valid3 = lane_vld[3];
endmodule

// File: tb/tb_rr_dispatch_1to4.sv
// Bench for rr_dispatch_1to4: behavioural lane/pointer model checked every
// cycle, plus directed literal expectations. Honours RR_DISPATCH_SKIP_BUSY_EN.
module tb_rr_dispatch_1to4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0][W-1:0] od;
    logic [3:0]     ov;
    logic [3:0]     rdy = 4'hF;
    logic           sel0, sel1, busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_dispatch_1to4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data0(od[0]), .out_data1(od[1]), .out_data2(od[2]), .out_data3(od[3]),
        .out_valid0(ov[0]), .out_valid1(ov[1]), .out_valid2(ov[2]), .out_valid3(ov[3]),
        .out_ready0(rdy[0]), .out_ready1(rdy[1]), .out_ready2(rdy[2]), .out_ready3(rdy[3]),
        .sel0(sel0), .sel1(sel1), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         mv [4];
    logic [7:0] md [4];
    int         mptr  = 0;
    bit         mlive = 0;
    int         acc_lane [$];

    // lane the next word would go to, or -1 if none can take it
    function automatic int m_target();
`ifdef RR_DISPATCH_SKIP_BUSY_EN
        for (int k = 0; k < 4; k++)
            if (!mv[(mptr + k) % 4] || rdy[(mptr + k) % 4]) return (mptr + k) % 4;
        return -1;
`else
        return (!mv[mptr] || rdy[mptr]) ? mptr : -1;
`endif
    endfunction

    function automatic bit m_ready();
        return !rst && (m_target() >= 0);
    endfunction

    function automatic bit m_busy();
        return mv[0] | mv[1] | mv[2] | mv[3];
    endfunction

    always @(posedge clk) begin
        int t;
        t = m_target();
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mv[i] <= 1'b0;
                md[i] <= '0;
            end
            mptr <= 0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mv[i] && rdy[i]) mv[i] <= 1'b0;
            if (in_valid && t >= 0) begin
                mv[t] <= 1'b1;
                md[t] <= in_data;
                mptr  <= (t + 1) % 4;
                acc_lane.push_back(t);
            end
        end
        mlive <= 1'b1;
    end

    // compare everything on the falling edge
    always @(negedge clk) begin
        if (mlive) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("m_valid%0d", i), 32'(ov[i]), 32'(mv[i]));
                chk($sformatf("m_data%0d", i), 32'(od[i]), 32'(md[i]));
            end
            chk("m_sel", 32'({sel1, sel0}), 32'(mptr));
            chk("m_busy", 32'(busy), 32'(m_busy()));
            chk("m_in_ready", 32'(in_ready), 32'(m_ready()));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input logic [7:0] d, input logic [3:0] r);
        in_valid = v;
        in_data  = d;
        rdy      = r;
    endtask

    logic [7:0] t1w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int         t1l [5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset
        drv(0, 8'h00, 4'hF);
        rst = 1'b1;
        step();
        step();
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_valid", 32'(ov), 0);
        chk("rst_sel", 32'({sel1, sel0}), 0);
        rst = 1'b0;

        // stream 5 words, all consumers ready
        acc_lane.delete();
        for (int i = 0; i < 5; i++) begin
            drv(1, t1w[i], 4'hF);
            #1;
            chk("t1_in_ready", 32'(in_ready), 1);
            chk("t1_sel", 32'({sel1, sel0}), 32'(i % 4));
            step();
            chk("t1_data", 32'(od[t1l[i]]), 32'(t1w[i]));
            chk("t1_valid", 32'(ov[t1l[i]]), 1);
        end
        chk("t1_sel_end", 32'({sel1, sel0}), 1);
        chk("t1_nacc", 32'(acc_lane.size()), 5);
        for (int i = 0; i < 5 && i < acc_lane.size(); i++)
            chk("t1_lane", 32'(acc_lane[i]), 32'(t1l[i]));
        drv(0, 8'h00, 4'hF);
        step();

        // fill all lanes with consumers stalled
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1, 8'hA0 + 8'(i), 4'h0);
            step();
        end
        drv(1, 8'hA4, 4'h0);
        #1;
        chk("t2_full_in_ready", 32'(in_ready), 0);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_valid", 32'(ov), 32'hF);
        step();
        chk("t2_data3", 32'(od[3]), 32'hA3);
        drv(1, 8'hA4, 4'b0001);
        #1;
        chk("t2_drain_in_ready", 32'(in_ready), 1);
        step();
        chk("t2_lane0", 32'(od[0]), 32'hA4);
        chk("t2_lane0_valid", 32'(ov[0]), 1);
        chk("t2_sel", 32'({sel1, sel0}), 1);

        // leave only lane 1 full, ptr = 1
        drv(0, 8'h00, 4'b1101);
        step();
        chk("t3_setup_valid", 32'(ov), 32'b0010);

`ifndef RR_DISPATCH_SKIP_BUSY_EN
        drv(1, 8'hB1, 4'b1101);
        #1;
        chk("t3_blocked", 32'(in_ready), 0);
        step();
        chk("t3_sel_hold", 32'({sel1, sel0}), 1);
        drv(1, 8'hB1, 4'b0010);
        #1;
        chk("t3_release", 32'(in_ready), 1);
        step();
        chk("t3_lane1", 32'(od[1]), 32'hB1);
        chk("t3_lane1_valid", 32'(ov[1]), 1);
        chk("t3_sel", 32'({sel1, sel0}), 2);
        drv(1, 8'hD2, 4'h0);
        step();
        drv(1, 8'hD3, 4'h0);
        step();
`else
        drv(1, 8'hC0, 4'h0);
        #1;
        chk("t4_in_ready", 32'(in_ready), 1);
        step();
        chk("t4_lane2", 32'(od[2]), 32'hC0);
        chk("t4_lane2_valid", 32'(ov[2]), 1);
        chk("t4_sel3", 32'({sel1, sel0}), 3);
        drv(1, 8'hC1, 4'h0);
        step();
        chk("t4_lane3", 32'(od[3]), 32'hC1);
        chk("t4_sel0", 32'({sel1, sel0}), 0);
`endif
        chk("t5_pre_valid", 32'(ov), 32'b1110);

        // reset with three lanes holding data
        drv(0, 8'h00, 4'h0);
        rst = 1'b1;
        #1;
        chk("t5_rst_in_ready", 32'(in_ready), 0);
        step();
        chk("t5_valid", 32'(ov), 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t5_data%0d", i), 32'(od[i]), 0);
        chk("t5_sel", 32'({sel1, sel0}), 0);
        chk("t5_busy", 32'(busy), 0);
        rst = 1'b0;
        #1;
        chk("t5_post_in_ready", 32'(in_ready), 1);

        // wrap: 9 accepts, all lanes draining
        acc_lane.delete();
        for (int i = 0; i < 9; i++) begin
            drv(1, 8'h60 + 8'(i), 4'hF);
            step();
        end
        chk("t6_lane0", 32'(od[0]), 32'h68);
        chk("t6_lane0_valid", 32'(ov[0]), 1);
        chk("t6_sel", 32'({sel1, sel0}), 1);
        chk("t6_nacc", 32'(acc_lane.size()), 9);
        if (acc_lane.size() == 9)
            chk("t6_last_lane", 32'(acc_lane[8]), 0);
        drv(0, 8'h00, 4'hF);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_dispatch_1to4.md
# rr_dispatch_1to4

Round-robin dispatcher that accepts a single valid/ready word stream and distributes successive words across four output lanes, each with a one-entry holding register. It sits directly upstream of the 1-to-4 demultiplexer stage. It drives that stage's selector pair as `sel1`/`sel0`, with lane index = {sel1, sel0}. It adds per-lane buffering and backpressure, so a slow consumer on one lane does not lose data.

## Interface
Parameters:
- `WIDTH`, default 8: data word width.

Ports:
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `in_data`  input  WIDTH  incoming word.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  dispatcher accepts `in_data` this cycle.
- `out_data0`..`out_data3`  output  WIDTH each  lane holding-register contents.
- `out_valid0`..`out_valid3`  output  1 each  lane holds an undelivered word.
- `out_ready0`..`out_ready3`  input  1 each  lane consumer takes the word this cycle.
- `sel0`, `sel1`  output  1 each  current target lane pointer, bit 0 and bit 1.
- `busy`  output  1  OR of all `out_validN`.

## Operation
- State:
  - 2-bit pointer `ptr`, exposed as {sel1, sel0}.
  - Per lane: a valid bit and a WIDTH data register.
- A lane is *free* when its valid bit is 0, or when it drains this cycle (`out_validN & out_readyN`).
- Accept: `in_valid & in_ready`. On accept, the target lane loads `in_data` and sets valid.
- Drain: `out_validN & out_readyN` clears lane N valid, unless that lane is also written the same cycle. In that case valid stays 1 and the data takes the new word (bubble-free).
- Pointer advance on accept: `ptr <= target + 1` mod 4, wrapping 3 -> 0. No accept means `ptr` holds.
- Default (strict) mode:
  - target = `ptr`.
  - `in_ready` = lane `ptr` free.
  - Words are delivered strictly in rotation 0,1,2,3,0,...
  - A stalled lane blocks the input.
- `in_ready` is combinational from lane state and `out_readyN`. It does not depend on `in_valid`.
- `out_dataN` holds its value while `out_validN`=0. It is not cleared on drain.
- Reset values (while `rst`=1 and on the first cycle after):
  - `ptr`=0, so `sel0`=`sel1`=0.
  - All `out_validN`=0 and all `out_dataN`=0.
  - `busy`=0.
  - `in_ready`=0 while `rst` is high.
- Reset mid-operation discards all held words. No partial state survives.

## Timing
- Latency: a word accepted at edge k is visible on `out_dataN`/`out_validN` after edge k. It can be drained at edge k+1 at the earliest.
- Throughput: 1 word/cycle while the target lanes are free.
- Simultaneous drain and refill of the same lane in one cycle is allowed and required.
- `sel0`/`sel1` change only on an accepting edge or on reset.
- `busy` is registered-state derived: it is the OR of the valid bits, with no combinational path from inputs.

## Configuration
- Macro `RR_DISPATCH_SKIP_BUSY_EN`.
- Defined:
  - target = first free lane searching `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - `in_ready` = any lane free.
  - After accept, `ptr` = target + 1. A stalled lane is skipped, not waited on.
  - {sel1, sel0} reflects `ptr` (the search start), not the target.
- Undefined: strict rotation as described in Operation.

## Test plan
- Reset, then stream 0x11,0x22,0x33,0x44,0x55 with all `out_readyN`=1 -> lanes 0,1,2,3,0 receive them in order; `in_ready` stays 1; {sel1,sel0} steps 0,1,2,3,0,1.
- Fill all lanes (0xA0..0xA3) with all `out_readyN`=0 -> `in_ready`=0, `busy`=1, all `out_validN`=1; raise `out_ready0` -> next word 0xA4 lands in lane 0 the same edge lane 0 drains.
- Strict mode, `out_ready1` held 0, lane 1 full, `ptr`=1 -> `in_ready`=0 even with lanes 0,2,3 empty; releasing `out_ready1` for one cycle -> 0xB1 accepted into lane 1, `ptr`=2.
- `RR_DISPATCH_SKIP_BUSY_EN` defined, lane 1 full and stalled, `ptr`=1 -> 0xC0 goes to lane 2, `ptr`=3; next 0xC1 goes to lane 3, `ptr`=0.
- Assert `rst` for one cycle with 3 lanes holding data -> all `out_validN`=0, `out_dataN`=0, `ptr`=0, `busy`=0; `in_ready`=0 during reset and 1 the next cycle.
- Wrap check: 9 consecutive accepts, all lanes draining every cycle -> the 9th word lands in lane 0, and the pointer ends at 1.
